// File: rtl/decode_queue.sv
// RV32I(+M) instruction decoder feeding a small in-order queue of decoded entries.
// Entries are decoded on entry so the consumer sees registered, ready-to-issue fields.
module decode_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned EN_M  = 0,
   parameter int unsigned CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_inst,
   input  logic [31:0]                  in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_pc,
   output logic [4:0]                   out_rd,
   output logic [4:0]                   out_rs1,
   output logic [4:0]                   out_rs2,
   output logic [31:0]                  out_imm,
   output logic [4:0]                   out_alu_op,
   output logic [4:0]                   out_mem_op,
   output logic                         out_wb_en,
   output logic [1:0]                   out_wb_src,
   output logic                         out_is_jump,
   output logic                         out_is_branch,
   output logic                         out_is_csr,
   output logic                         out_illegal,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_W-1:0]             illegal_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CNT_W-1:0] ILL_ONE = CNT_W'(1);

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_SYSTEM = 7'b1110011
   } opcode_e;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_SLL    = 5'd2;
   localparam logic [4:0] ALU_SLT    = 5'd3;
   localparam logic [4:0] ALU_SLTU   = 5'd4;
   localparam logic [4:0] ALU_XOR    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_OR     = 5'd8;
   localparam logic [4:0] ALU_AND    = 5'd9;
   localparam logic [4:0] ALU_CSRSET = 5'd10;
   localparam logic [4:0] ALU_CSRCLR = 5'd11;
   localparam logic [4:0] MEM_NONE   = 5'b00010;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [4:0]  alu_op;
      logic [4:0]  mem_op;
      logic        wb_en;
      logic [1:0]  wb_src;
      logic        is_jump;
      logic        is_branch;
      logic        is_csr;
      logic        illegal;
   } entry_t;

   entry_t        dec;
   entry_t        head;
   entry_t        mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          push;
   logic          pop;
   logic [2:0]    f3;
   logic [6:0]    f7;
   opcode_e       opc;

   assign f3  = in_inst[14:12];
   assign f7  = in_inst[31:25];
   assign opc = opcode_e'(in_inst[6:0]);

   function automatic logic [4:0] alu_of(input logic [2:0] fn, input logic alt);
      logic [4:0] r;
      case (fn)
         3'd0:    r = alt ? ALU_SUB : ALU_ADD;
         3'd1:    r = ALU_SLL;
         3'd2:    r = ALU_SLT;
         3'd3:    r = ALU_SLTU;
         3'd4:    r = ALU_XOR;
         3'd5:    r = alt ? ALU_SRA : ALU_SRL;
         3'd6:    r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

   always_comb begin
      dec        = '0;
      dec.pc     = in_pc;
      dec.rd     = in_inst[11:7];
      dec.rs1    = in_inst[19:15];
      dec.rs2    = in_inst[24:20];
      dec.mem_op = MEM_NONE;
      case (opc)
         OPC_LUI: begin
            dec.imm   = {in_inst[31:12], 12'b0};
            dec.wb_en = 1'b1;
         end
         OPC_AUIPC: begin
            dec.imm   = {in_inst[31:12], 12'b0};
            dec.wb_en = 1'b1;
         end
         OPC_JAL: begin
            dec.imm     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            dec.wb_en   = 1'b1;
            dec.is_jump = 1'b1;
         end
         OPC_JALR: begin
            dec.imm     = {{20{in_inst[31]}}, in_inst[31:20]};
            dec.wb_en   = 1'b1;
            dec.is_jump = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm       = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
            dec.is_branch = 1'b1;
            // BEQ/BNE compare by subtraction, BLT/BGE by SLT, BLTU/BGEU by SLTU
            case (f3[2:1])
               2'b00:   dec.alu_op = ALU_SUB;
               2'b10:   dec.alu_op = ALU_SLT;
               2'b11:   dec.alu_op = ALU_SLTU;
               default: dec.illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec.imm    = {{20{in_inst[31]}}, in_inst[31:20]};
            dec.wb_en  = 1'b1;
            dec.wb_src = 2'd1;
            dec.mem_op = {2'b01, ~f3[2], f3[1:0]};
            dec.illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         end
         OPC_STORE: begin
            dec.imm     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            dec.mem_op  = {2'b10, 1'b0, f3[1:0]};
            dec.illegal = (f3 > 3'd2);
         end
         OPC_OP_IMM: begin
            dec.wb_en = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               dec.imm     = {27'b0, in_inst[24:20]};
               dec.alu_op  = alu_of(f3, f7[5]);
               dec.illegal = (f3 == 3'd1) ? (f7 != 7'b0)
                                          : (f7 != 7'b0 && f7 != 7'b0100000);
            end else begin
               dec.imm    = {{20{in_inst[31]}}, in_inst[31:20]};
               dec.alu_op = alu_of(f3, 1'b0);
            end
         end
         OPC_OP: begin
            dec.wb_en = 1'b1;
            if (f7 == 7'b0000001) begin
               dec.alu_op  = {2'b10, f3};
               dec.illegal = (EN_M == 0);
            end else begin
               dec.alu_op  = alu_of(f3, f7[5]);
               dec.illegal = !((f7 == 7'b0) ||
                               (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)));
            end
         end
         OPC_SYSTEM: begin
            dec.imm = {27'b0, in_inst[19:15]};
            if (f3 != 3'd0) begin
               dec.is_csr = 1'b1;
               dec.wb_en  = 1'b1;
               dec.wb_src = 2'd2;
               case (f3[1:0])
                  2'b10:   dec.alu_op = ALU_CSRSET;
                  2'b11:   dec.alu_op = ALU_CSRCLR;
                  default: dec.alu_op = ALU_ADD;
               endcase
            end
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.illegal) begin
         dec.wb_en     = 1'b0;
         dec.wb_src    = 2'd0;
         dec.mem_op    = MEM_NONE;
         dec.alu_op    = ALU_ADD;
         dec.is_jump   = 1'b0;
         dec.is_branch = 1'b0;
         dec.is_csr    = 1'b0;
      end
   end

   assign in_ready  = (count < FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= dec;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) illegal_count <= '0;
      else if (push && dec.illegal && illegal_count != '1)
         illegal_count <= illegal_count + ILL_ONE;
   end

   assign head          = out_valid ? mem[rptr] : '0;
   assign out_pc        = head.pc;
   assign out_rd        = head.rd;
   assign out_rs1       = head.rs1;
   assign out_rs2       = head.rs2;
   assign out_imm       = head.imm;
   assign out_alu_op    = head.alu_op;
   assign out_mem_op    = head.mem_op;
   assign out_wb_en     = head.wb_en;
   assign out_wb_src    = head.wb_src;
   assign out_is_jump   = head.is_jump;
   assign out_is_branch = head.is_branch;
   assign out_is_csr    = head.is_csr;
   assign out_illegal   = head.illegal;

endmodule
